// File: rtl/axi4_lite_pkg.sv
// AXI4-lite shared types for the command master.
// Response codes, default protection and error decode.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are the failing responses
  function automatic logic resp_is_err(input logic [1:0] r);
    return (resp_e'(r) == SLVERR) || (resp_e'(r) == DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-lite master driven by a simple
// valid/ready command channel; all outputs are registered.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_stb,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic [AW-1:0]   awaddr,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic [AW-1:0]   araddr,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RA, RD, RSP
  } state_e;

  state_e state, state_nx;

  logic accept, aw_hs, w_hs, b_hs;
  logic ar_hs, r_hs, rsp_hs;
  logic awvalid_d, wvalid_d, arvalid_d;
  logic bready_d, rready_d, rsp_vld_d, cmd_rdy_d;

  assign accept = cmd_vld & cmd_rdy;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign rsp_hs = rsp_vld & rsp_rdy;

  assign awprot = PROT_DEFAULT;
  assign arprot = PROT_DEFAULT;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; WR ends once each channel has handshaken
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = cmd_wr ? WR : RA;
      WR: if ((!awvalid || awready) &&
              (!wvalid || wready))
            state_nx = WB;
      WB:   if (b_hs)   state_nx = RSP;
      RA:   if (ar_hs)  state_nx = RD;
      RD:   if (r_hs)   state_nx = RSP;
      RSP:  if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    awvalid_d = awvalid;
    wvalid_d  = wvalid;
    arvalid_d = arvalid;
    if (accept && cmd_wr) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs)  wvalid_d  = 1'b0;
    if (accept && !cmd_wr) arvalid_d = 1'b1;
    if (ar_hs) arvalid_d = 1'b0;
    bready_d  = (state_nx == WB);
    rready_d  = (state_nx == RD);
    rsp_vld_d = (state_nx == RSP);
    cmd_rdy_d = (state_nx == IDLE);
  end

  // Output and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      bready  <= 1'b0;
      rready  <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      cmd_rdy <= 1'b0;
      rsp_dat <= '0;
      awaddr  <= '0;
      araddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      arvalid <= arvalid_d;
      bready  <= bready_d;
      rready  <= rready_d;
      rsp_vld <= rsp_vld_d;
      cmd_rdy <= cmd_rdy_d;
      if (accept && cmd_wr) begin
        awaddr <= cmd_adr;
        wdata  <= cmd_dat;
        wstrb  <= cmd_stb;
      end
      if (accept && !cmd_wr) araddr <= cmd_adr;
      if (b_hs) begin
        rsp_dat <= '0;
        rsp_err <= resp_is_err(bresp);
      end
      if (r_hs) begin
        rsp_dat <= rdata;
        rsp_err <= resp_is_err(rresp);
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Scoreboard bench for axi4_lite_cmd_master with a
// register-file slave model and protocol stability checks.
module tb_axi4_lite_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld, cmd_rdy, cmd_wr;
  logic [31:0]   cmd_adr, cmd_dat;
  logic [3:0]    cmd_stb;
  logic          rsp_vld, rsp_rdy, rsp_err;
  logic [31:0]   rsp_dat;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready;

  always #5 clk = ~clk;

  axi4_lite_cmd_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_wr(cmd_wr), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_stb(cmd_stb),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .awaddr(awaddr), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  int          w_delay = 0;
  int          r_delay = 0;
  logic [1:0]  b_code = 2'b00;
  logic [1:0]  r_code = 2'b00;
  logic        r_force = 1'b0;
  logic [31:0] r_force_dat = 32'h0;
  logic [31:0] mem [16];
  int          aw_cnt, w_cnt, r_wait;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] got_adr, got_dat, rd_dat;
  logic [3:0]  got_stb;
  logic        aw_ok, w_ok;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_stb;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;
  assign bvalid  = b_pend;
  assign bresp   = b_code;
  assign rvalid  = r_pend && (r_wait == 0);
  assign rdata   = rd_dat;
  assign rresp   = r_code;
  assign aw_ok   = aw_got || (awvalid && awready);
  assign w_ok    = w_got || (wvalid && wready);
  assign cur_adr = (awvalid && awready) ? awaddr : got_adr;
  assign cur_dat = (wvalid && wready) ? wdata : got_dat;
  assign cur_stb = (wvalid && wready) ? wstrb : got_stb;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0;
      got_adr <= 0; got_dat <= 0; got_stb <= 0;
      rd_dat <= 0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (awready)        aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt <= w_cnt + 1;
      else if (wready)         w_cnt <= 0;
      if (awvalid && awready) begin
        aw_got <= 1'b1; got_adr <= awaddr;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; got_dat <= wdata; got_stb <= wstrb;
      end
      if (aw_ok && w_ok) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
        for (int i = 0; i < 4; i++)
          if (cur_stb[i])
            mem[cur_adr[5:2]][8*i +: 8] <= cur_dat[8*i +: 8];
      end
      if (bvalid && bready) b_pend <= 1'b0;
      if (arvalid && arready) begin
        r_pend <= 1'b1;
        r_wait <= r_delay;
        rd_dat <= r_force ? r_force_dat : mem[araddr[5:2]];
      end else if (r_pend && r_wait != 0) begin
        r_wait <= r_wait - 1;
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  // ---------------- protocol checks ----------------
  int          aw_hi = 0;
  int          w_hi = 0;
  logic        b_early = 1'b0;
  logic        p_rst = 1'b1;
  logic        p_aw_wait = 0, p_w_wait = 0;
  logic        p_ar_wait = 0, p_rsp_wait = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdat;
  logic [3:0]  p_wstrb;
  logic        p_rerr;

  always @(negedge clk) begin
    if (!p_rst) begin
      if (p_aw_wait)
        check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w_wait)
        check("w_stable", {wvalid, wstrb, wdata},
              {1'b1, p_wstrb, p_wdata});
      if (p_ar_wait)
        check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_rsp_wait)
        check("rsp_stable", {rsp_vld, rsp_err, rsp_dat},
              {1'b1, p_rerr, p_rdat});
    end
    if (awvalid) aw_hi++;
    if (wvalid)  w_hi++;
    if (bready && (awvalid || wvalid)) b_early = 1'b1;
    p_aw_wait  = awvalid && !awready;
    p_w_wait   = wvalid && !wready;
    p_ar_wait  = arvalid && !arready;
    p_rsp_wait = rsp_vld && !rsp_rdy;
    p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
    p_araddr = araddr; p_rdat = rsp_dat; p_rerr = rsp_err;
    p_rst = rst;
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got dat=%0h err=%0b, none queued",
                 rsp_dat, rsp_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp", {rsp_err, rsp_dat}, e);
        last_rsp_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic wr, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] stb,
                      input logic [31:0] edat, input logic eerr,
                      input bit push);
    int n;
    exp_t e;
    e.err = eerr;
    e.dat = edat;
    if (push) sbq.push_back(e);
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_wr = wr; cmd_adr = adr;
    cmd_dat = dat; cmd_stb = stb;
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_timeout: cmd_rdy=%0b required 1", cmd_rdy);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0",
               name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_lat(input string name, input int exp);
    check(name, 64'(last_rsp_cyc - acc_cyc), 64'(exp));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_adr = 0;
    cmd_dat = 0; cmd_stb = 0; rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl",
          {cmd_rdy, awvalid, wvalid, bready, arvalid,
           rready, rsp_vld, rsp_err}, 0);
    check("reset_dat", {rsp_dat, awaddr}, 0);
    check("reset_dat2", {araddr, wdata}, 0);
    check("reset_strb_prot", {wstrb, awprot, arprot}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cmd_rdy_after_rst", cmd_rdy, 1);

    send(1'b1, 32'h00, 32'h67, 4'hf, 32'h0, 1'b0, 1);
    wait_done("wr0");
    check_lat("wr_latency", 3);
    send(1'b0, 32'h00, 32'h0, 4'h0, 32'h67, 1'b0, 1);
    wait_done("rd0");
    check_lat("rd_latency", 3);
    send(1'b1, 32'h04, 32'ha5, 4'h1, 32'h0, 1'b0, 1);
    wait_done("wr4");
    send(1'b0, 32'h04, 32'h0, 4'h0, 32'ha5, 1'b0, 1);
    wait_done("rd4");
    check_lat("rd4_latency", 3);

    aw_delay = 3;
    @(posedge clk); #1;
    aw_hi = 0; w_hi = 0; b_early = 1'b0;
    send(1'b1, 32'h08, 32'h1234_5678, 4'hf, 32'h0, 1'b0, 1);
    wait_done("aw_delay");
    check("awvalid_cycles", 64'(aw_hi), 4);
    check("wvalid_cycles", 64'(w_hi), 1);
    check("bready_early", b_early, 0);
    check_lat("aw_delay_latency", 6);
    aw_delay = 0;
    send(1'b0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);
    wait_done("rd8");

    b_code = 2'b10;
    send(1'b1, 32'h0c, 32'h55, 4'hf, 32'h0, 1'b1, 1);
    wait_done("bresp_err");
    b_code = 2'b00;
    r_code = 2'b11; r_force = 1'b1; r_force_dat = 32'hcafe_f00d;
    send(1'b0, 32'h0c, 32'h0, 4'h0, 32'hcafe_f00d, 1'b1, 1);
    wait_done("rresp_err");
    r_code = 2'b00; r_force = 1'b0;

    rsp_rdy = 1'b0;
    send(1'b0, 32'h04, 32'h0, 4'h0, 32'ha5, 1'b0, 1);
    n = 0;
    while (!rsp_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_seen", rsp_vld, 1);
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_adr = 32'h10;
    cmd_dat = 32'hffff_ffff; cmd_stb = 4'hf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold",
            {rsp_vld, rsp_dat, cmd_rdy, awvalid, arvalid},
            {1'b1, 32'ha5, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    rsp_rdy = 1'b1;
    wait_done("stall");
    @(negedge clk);
    check("stall_no_accept", {awvalid, arvalid}, 0);

    r_delay = 10;
    send(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_rd", rready, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_rd",
          {awvalid, wvalid, bready, arvalid, rready, rsp_vld, cmd_rdy},
          0);
    r_delay = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_vld, 0);
    end
    send(1'b0, 32'h00, 32'h0, 4'h0, 32'h67, 1'b0, 1);
    wait_done("rd_after_rst");
    check_lat("rd_after_rst_latency", 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_cmd_master.md
AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width, multiple of 8.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all logic.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_vld in 1 / cmd_rdy out 1 / cmd_wr in 1 (1=write) / cmd_adr in AW / cmd_dat in DW / cmd_stb in DW/8: command channel.
REQ-006 rsp_vld out 1 / rsp_rdy in 1 / rsp_dat out DW / rsp_err out 1: response channel.
REQ-007 awaddr out AW, awprot out 3, awvalid out 1, awready in 1: AXI4-lite write address.
REQ-008 wdata out DW, wstrb out DW/8, wvalid out 1, wready in 1: AXI4-lite write data.
REQ-009 bresp in 2, bvalid in 1, bready out 1: AXI4-lite write response.
REQ-010 araddr out AW, arprot out 3, arvalid out 1, arready in 1: AXI4-lite read address.
REQ-011 rdata in DW, rresp in 2, rvalid in 1, rready out 1: AXI4-lite read data.

Function
REQ-012 SHALL implement FSM states IDLE, WR (AW/W outstanding), WB (await B), RA (await AR), RD (await R), RSP (hold response).
REQ-013 cmd_rdy SHALL be 1 only in IDLE; a command is accepted on cmd_vld&cmd_rdy and registered (adr, dat, stb, wr).
REQ-014 On accepted write: next cycle state WR, awvalid=1 and wvalid=1 simultaneously, awaddr=cmd_adr, wdata=cmd_dat, wstrb=cmd_stb.
REQ-015 In WR, awvalid SHALL drop the cycle after its own handshake and wvalid likewise, independently; order of the two handshakes is arbitrary, same-cycle allowed.
REQ-016 When both AW and W handshakes have completed: state WB, bready=1; bready SHALL never be 1 before both complete.
REQ-017 On bvalid&bready: state RSP, rsp_dat=0, rsp_err=bresp[1].
REQ-018 On accepted read: next cycle state RA, arvalid=1, araddr=cmd_adr; on arready: state RD, arvalid=0, rready=1.
REQ-019 On rvalid&rready: state RSP, rsp_dat=rdata, rsp_err=rresp[1].
REQ-020 awprot and arprot SHALL be constant 3'b000; addresses passed unmodified.
REQ-021 Once asserted, valid outputs and their payload SHALL stay stable until handshake (AXI rule); independent of ready.
REQ-022 In RSP, rsp_vld=1 with stable rsp_dat/rsp_err until rsp_vld&rsp_rdy, then IDLE next cycle.
REQ-023 Latency with zero-wait slave and rsp_rdy=1: write accept cycle 0, AW/W cycle 1, B cycle 2, rsp_vld cycle 3; read accept 0, AR 1, R 2, rsp_vld 3.
REQ-024 At most one transaction outstanding; no new command until response consumed (cmd_rdy low in all non-IDLE states).
REQ-025 Unsolicited bvalid/rvalid (outside WB/RD) SHALL be ignored (ready held 0).
REQ-026 All AXI and response outputs SHALL be registered, no combinational path from any input to any output except none.

Reset
REQ-027 On rst=1 at clk edge: state IDLE; awvalid, wvalid, bready, arvalid, rready, rsp_vld, rsp_err = 0; rsp_dat, awaddr, araddr, wdata, wstrb = 0.
REQ-028 Reset mid-transaction SHALL abandon it without response; the attached slave is reset by the same rst.
REQ-029 cmd_rdy SHALL be 0 while rst=1 and 1 the first cycle after release.

Structure
REQ-030 axi4_lite_pkg SHALL hold resp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and PROT_DEFAULT constant.
REQ-031 FSM state enum SHALL be local to the module; no sub-module is required.

Verification
REQ-032 Against gpio slave: write 0x00=0x67, then read 0x00 -> rsp_dat=0x67, rsp_err=0; write 0x04=0xa5, read 0x04 -> 0xa5.
REQ-033 Slave awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held 4 cycles, bready rises only after AW handshake.
REQ-034 Slave returns bresp=2'b10 -> rsp_err=1, rsp_dat=0; rresp=2'b11 on read -> rsp_err=1, rsp_dat=rdata.
REQ-035 rsp_rdy held 0 for 5 cycles -> rsp_vld and rsp_dat stable 5 cycles, cmd_rdy 0, new cmd_vld not accepted.
REQ-036 rst asserted while in RD -> next cycle all valids/readies 0, state IDLE, no rsp_vld; subsequent read completes correctly.
